// File: rtl/stack_pkg.sv
// Shared definitions for the 8051 stack sequencer: op encodings, FSM states, default depth.
package stack_pkg;

  localparam int STACK_DEPTH = 8;

  localparam logic [1:0] OP_PUSH8  = 2'd0;
  localparam logic [1:0] OP_POP8   = 2'd1;
  localparam logic [1:0] OP_CALL16 = 2'd2;
  localparam logic [1:0] OP_RET16  = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_LO,
    PUSH_HI,
    POP_A,
    POP_B,
    POP_CAP,
    RESP
  } state_e;

  function automatic logic op_is_push(input logic [1:0] op);
    return (op == OP_PUSH8) || (op == OP_CALL16);
  endfunction

  function automatic logic op_is_wide(input logic [1:0] op);
    return (op == OP_CALL16) || (op == OP_RET16);
  endfunction

endpackage

// File: rtl/stack_arb.sv
// Fixed-priority (irq over core) request arbiter with latch of the accepted request.
module stack_arb
  import stack_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        grant_en,
  input  logic        irq_valid,
  input  logic [15:0] irq_pc,
  input  logic        core_valid,
  input  logic [1:0]  core_op,
  input  logic [15:0] core_data,
  output logic        irq_ready,
  output logic        core_ready,
  output logic        win_valid,
  output logic [1:0]  win_op,
  output logic [1:0]  req_op,
  output logic [15:0] req_data,
  output logic        req_src
);

  logic [15:0] win_data;

  always_comb begin
    irq_ready  = grant_en & irq_valid;
    core_ready = grant_en & core_valid & ~irq_valid;
    win_valid  = irq_ready | core_ready;
    win_op     = irq_valid ? OP_CALL16 : core_op;
    win_data   = irq_valid ? irq_pc : core_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_op   <= OP_PUSH8;
      req_data <= '0;
      req_src  <= 1'b0;
    end else if (win_valid) begin
      req_op   <= win_op;
      req_data <= win_data;
      req_src  <= irq_ready;
    end
  end

endmodule

// File: rtl/stack_ctrl.sv
// Stack sequencer: splits PUSH8/POP8/CALL16/RET16 into byte accesses with occupancy checks.
// Optional high-water mark tracking enabled by defining STACK_CTRL_HIGHWATER_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH,
  parameter int OCC_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             core_valid,
  input  logic [1:0]       core_op,
  input  logic [15:0]      core_data,
  output logic             core_ready,
  input  logic             irq_valid,
  input  logic [15:0]      irq_pc,
  output logic             irq_ready,
  output logic             rsp_valid,
  output logic             rsp_src,
  output logic             rsp_err,
  output logic [15:0]      rsp_data,
  output logic [OCC_W-1:0] occupancy,
  output logic             stk_enable,
  output logic             stk_pushpop,
  output logic [7:0]       stk_data_in,
  input  logic [7:0]       stk_data_out
`ifdef STACK_CTRL_HIGHWATER_EN
  ,
  output logic [OCC_W-1:0] hw_mark,
  input  logic             hw_clear
`endif
);

  localparam logic [OCC_W:0] DEPTH_X = (OCC_W+1)'(DEPTH);

  state_e          state, state_nxt;
  logic            win_valid;
  logic [1:0]      win_op;
  logic [1:0]      req_op;
  logic [15:0]     req_data;
  logic            req_src;
  logic [OCC_W:0]  occ_ext, need;
  logic            reject;
  logic            err_q;
  logic [15:0]     data_q;
  logic [OCC_W-1:0] occ_nxt;

  stack_arb u_arb (
    .clock      (clock),
    .reset      (reset),
    .grant_en   (state == IDLE),
    .irq_valid  (irq_valid),
    .irq_pc     (irq_pc),
    .core_valid (core_valid),
    .core_op    (core_op),
    .core_data  (core_data),
    .irq_ready  (irq_ready),
    .core_ready (core_ready),
    .win_valid  (win_valid),
    .win_op     (win_op),
    .req_op     (req_op),
    .req_data   (req_data),
    .req_src    (req_src)
  );

  // Checks use the incoming winner so a rejected request never leaves IDLE for a stack state.
  always_comb begin
    occ_ext = {1'b0, occupancy};
    need    = op_is_wide(win_op) ? (OCC_W+1)'(2) : (OCC_W+1)'(1);
    if (op_is_push(win_op)) reject = (occ_ext + need) > DEPTH_X;
    else                    reject = occ_ext < need;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_valid) begin
                 if (reject)                 state_nxt = RESP;
                 else if (op_is_push(win_op)) state_nxt = PUSH_LO;
                 else                        state_nxt = POP_A;
               end
      PUSH_LO: state_nxt = (req_op == OP_CALL16) ? PUSH_HI : RESP;
      PUSH_HI: state_nxt = RESP;
      POP_A:   state_nxt = (req_op == OP_RET16) ? POP_B : POP_CAP;
      POP_B:   state_nxt = POP_CAP;
      POP_CAP: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stk_enable  = 1'b0;
    stk_pushpop = 1'b0;
    stk_data_in = '0;
    rsp_valid   = 1'b0;
    rsp_src     = 1'b0;
    rsp_err     = 1'b0;
    rsp_data    = '0;
    occ_nxt     = occupancy;
    unique case (state)
      PUSH_LO: begin
        stk_enable  = 1'b1;
        stk_pushpop = 1'b1;
        stk_data_in = req_data[7:0];
        occ_nxt     = occupancy + OCC_W'(1);
      end
      PUSH_HI: begin
        stk_enable  = 1'b1;
        stk_pushpop = 1'b1;
        stk_data_in = req_data[15:8];
        occ_nxt     = occupancy + OCC_W'(1);
      end
      POP_A, POP_B: begin
        stk_enable = 1'b1;
        occ_nxt    = occupancy - OCC_W'(1);
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_src   = req_src;
        rsp_err   = err_q;
        rsp_data  = data_q;
      end
      default: ;
    endcase
  end

  // The high byte of a RET16 comes off first; the low byte is captured last.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      occupancy <= occ_nxt;
      if (state == IDLE && win_valid) begin
        err_q  <= reject;
        data_q <= '0;
      end
      if (state == POP_B)   data_q[15:8] <= stk_data_out;
      if (state == POP_CAP) data_q[7:0]  <= stk_data_out;
    end
  end

`ifdef STACK_CTRL_HIGHWATER_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                hw_mark <= '0;
    else if (hw_clear || (occ_nxt > hw_mark))  hw_mark <= occ_nxt;
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed self-checking bench for stack_ctrl with a behavioural byte stack behind it.
module tb_stack_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        core_valid = 1'b0;
  logic [1:0]  core_op = 2'd0;
  logic [15:0] core_data = '0;
  logic        core_ready;
  logic        irq_valid = 1'b0;
  logic [15:0] irq_pc = '0;
  logic        irq_ready;
  logic        rsp_valid, rsp_src, rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  occupancy;
  logic        stk_enable, stk_pushpop;
  logic [7:0]  stk_data_in;
  logic [7:0]  stk_data_out;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int pulses_before;

  logic [7:0] mem [0:15];
  int         sp;

  stack_ctrl #(.DEPTH(8), .OCC_W(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .core_valid   (core_valid),
    .core_op      (core_op),
    .core_data    (core_data),
    .core_ready   (core_ready),
    .irq_valid    (irq_valid),
    .irq_pc       (irq_pc),
    .irq_ready    (irq_ready),
    .rsp_valid    (rsp_valid),
    .rsp_src      (rsp_src),
    .rsp_err      (rsp_err),
    .rsp_data     (rsp_data),
    .occupancy    (occupancy),
    .stk_enable   (stk_enable),
    .stk_pushpop  (stk_pushpop),
    .stk_data_in  (stk_data_in),
    .stk_data_out (stk_data_out)
  );

  always #5 clock = ~clock;

  // Byte stack model: popped byte appears the cycle after the pop strobe.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sp <= 0;
      stk_data_out <= 8'h00;
    end else if (stk_enable) begin
      pulses <= pulses + 1;
      if (stk_pushpop) begin
        mem[sp[3:0]] <= stk_data_in;
        sp <= sp + 1;
      end else begin
        stk_data_out <= mem[4'(sp - 1)];
        sp <= sp - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Present a core request for one cycle, then drop it; leaves time at the accept cycle + #2.
  task automatic core_req(input logic [1:0] op, input logic [15:0] d, input string tag);
    core_valid = 1'b1;
    core_op    = op;
    core_data  = d;
    #1;
    chk({tag, "_ready"}, core_ready, 1'b1);
    cyc();
    core_valid = 1'b0;
    #1;
  endtask

  // Run a PUSH8 to completion and return to IDLE.
  task automatic push8(input logic [7:0] d);
    core_req(2'd0, {8'h00, d}, "push8");
    cyc();
    chk("push8_rsp", {rsp_valid, rsp_err}, 2'b10);
    cyc();
  endtask

  task automatic pop8(input logic [7:0] d);
    core_req(2'd1, 16'h0, "pop8");
    cyc();
    cyc();
    chk("pop8_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b10, 8'h00, d});
    cyc();
  endtask

  initial begin
    #23;
    chk("rst_outs", {core_ready, irq_ready, rsp_valid, rsp_src, rsp_err, rsp_data, stk_enable, stk_pushpop, stk_data_in},
        '0);
    chk("rst_occ", occupancy, 4'd0);
    reset = 1'b1;
    cyc();

    // CALL16 0x1234: pushes 0x34 then 0x12, response 3 cycles after acceptance
    core_req(2'd2, 16'h1234, "call");
    chk("call_lo", {stk_enable, stk_pushpop, stk_data_in, occupancy}, {2'b11, 8'h34, 4'd0});
    cyc();
    chk("call_hi", {stk_enable, stk_pushpop, stk_data_in, occupancy}, {2'b11, 8'h12, 4'd1});
    chk("call_early", rsp_valid, 1'b0);
    cyc();
    chk("call_rsp", {rsp_valid, rsp_err, rsp_src, rsp_data, stk_enable}, {3'b100, 16'h0000, 1'b0});
    chk("call_occ", occupancy, 4'd2);
    cyc();
    chk("call_idle", rsp_valid, 1'b0);

    // RET16: pops 0x12 then 0x34, response 4 cycles after acceptance
    core_req(2'd3, 16'h0, "ret");
    chk("ret_popA", {stk_enable, stk_pushpop, occupancy}, {2'b10, 4'd2});
    cyc();
    chk("ret_popB", {stk_enable, stk_pushpop, occupancy, stk_data_out}, {2'b10, 4'd1, 8'h12});
    cyc();
    chk("ret_cap", {stk_enable, rsp_valid, occupancy, stk_data_out}, {2'b00, 4'd0, 8'h34});
    cyc();
    chk("ret_rsp", {rsp_valid, rsp_err, rsp_src, rsp_data}, {3'b100, 16'h1234});
    chk("ret_occ", occupancy, 4'd0);
    cyc();

    // Fill to 7, then CALL16 must be rejected whole
    for (int i = 0; i < 7; i++) push8(8'h10 + 8'(i));
    chk("fill7_occ", occupancy, 4'd7);
    pulses_before = pulses;
    core_req(2'd2, 16'hABCD, "call_full");
    chk("ovf_rsp", {rsp_valid, rsp_err, rsp_data, stk_enable}, {2'b11, 16'h0000, 1'b0});
    cyc();
    chk("ovf_occ", occupancy, 4'd7);
    chk("ovf_nopulse", pulses, pulses_before);

    // Last byte fits; one more overflows
    push8(8'hA5);
    chk("full_occ", occupancy, 4'd8);
    core_req(2'd0, 16'h00EE, "push_full");
    chk("ovf8_rsp", {rsp_valid, rsp_err, stk_enable}, 3'b110);
    cyc();
    chk("ovf8_occ", occupancy, 4'd8);

    // Drain in LIFO order
    pop8(8'hA5);
    pop8(8'h16);
    for (int i = 5; i >= 0; i--) pop8(8'h10 + 8'(i));
    chk("drain_occ", occupancy, 4'd0);

    // POP8 on an empty stack: error one cycle after acceptance
    pulses_before = pulses;
    core_req(2'd1, 16'h0, "pop_empty");
    chk("unf_rsp", {rsp_valid, rsp_err, rsp_data, stk_enable}, {2'b11, 16'h0000, 1'b0});
    cyc();
    chk("unf_nopulse", pulses, pulses_before);

    // Simultaneous irq and core: irq wins, core waits
    irq_valid = 1'b1; irq_pc = 16'hBEEF;
    core_valid = 1'b1; core_op = 2'd0; core_data = 16'h0077;
    #1;
    chk("arb_ready", {irq_ready, core_ready}, 2'b10);
    cyc();
    irq_valid = 1'b0;
    #1;
    chk("irq_lo", {core_ready, stk_enable, stk_data_in}, {2'b01, 8'hEF});
    cyc();
    chk("irq_hi", {core_ready, stk_enable, stk_data_in}, {2'b01, 8'hBE});
    cyc();
    chk("irq_rsp", {rsp_valid, rsp_src, rsp_err, core_ready}, 4'b1100);
    cyc();
    chk("core_late_ready", {core_ready, irq_ready}, 2'b10);
    cyc();
    core_valid = 1'b0;
    #1;
    chk("core_lo", {stk_enable, stk_data_in}, {1'b1, 8'h77});
    cyc();
    chk("core_rsp", {rsp_valid, rsp_src, rsp_err, occupancy}, {3'b100, 4'd3});
    cyc();

    // Reset during PUSH_HI of a CALL16
    core_req(2'd2, 16'hCAFE, "call_rst");
    cyc();
    chk("rst_mid_hi", {stk_enable, stk_data_in}, {1'b1, 8'hCA});
    reset = 1'b0;
    #1;
    chk("rst_mid_outs", {stk_enable, rsp_valid, rsp_err, rsp_data, core_ready}, '0);
    chk("rst_mid_occ", occupancy, 4'd0);
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    core_req(2'd1, 16'h0, "pop_after_rst");
    chk("pop_after_rst_err", {rsp_valid, rsp_err, rsp_data}, {2'b11, 16'h0000});
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
